// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: execute-side branch controls, LUT programming, InstROM port and decode handshake.
// No logic of its own; the fetch unit drives its outputs from registers (rom_addr follows the PC register).
// Back-pressure travels on inst_ready; inst_valid never depends combinationally on it.
interface if_fetch_unit_if #(
  parameter int PC_W      = 9,
  parameter int INST_W    = 9,
  parameter int CMP_W     = 8,
  parameter int OFF_W     = 6,
  parameter int LUT_DEPTH = 16
);
  localparam int IDX_W = $clog2(LUT_DEPTH);

  // execute-side controls
  logic              halt;
  logic              resume;
  logic              branchsig;
  logic              branchtype;
  logic [CMP_W-1:0]  cmp;
  logic [OFF_W-1:0]  br_offset;
  logic [IDX_W-1:0]  br_index;
  logic              lut_we;
  logic [PC_W-1:0]   lut_wdata;
  // InstROM port
  logic [PC_W-1:0]   rom_addr;
  logic [INST_W-1:0] rom_data;
  // toward decode
  logic [PC_W-1:0]   core;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              halted;
  logic              BranchOut;

  // fetch unit side
  modport master (
    input  halt, resume, branchsig, branchtype, cmp, br_offset, br_index,
           lut_we, lut_wdata, rom_data, inst_ready,
    output rom_addr, core, inst, inst_pc, inst_valid, halted, BranchOut
  );

  // environment side (execute, ROM, decode)
  modport slave (
    output halt, resume, branchsig, branchtype, cmp, br_offset, br_index,
           lut_we, lut_wdata, rom_data, inst_ready,
    input  rom_addr, core, inst, inst_pc, inst_valid, halted, BranchOut
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, addresses the InstROM, registers the fetched word toward decode.
// Latency: word at address A appears on inst one cycle after core == A is accepted; 1 word/cycle sustained.
// Back-pressure: inst_ready low holds inst/inst_pc/core; a taken branch flushes inst_valid even while stalled.
module if_fetch_unit #(
  parameter int              PC_W      = 9,
  parameter int              INST_W    = 9,
  parameter int              CMP_W     = 8,
  parameter int              OFF_W     = 6,
  parameter int              LUT_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input logic             clk,
  input logic             reset,
  if_fetch_unit_if.master bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   core_q, core_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              branch_out_q, branch_out_d;
  logic [PC_W-1:0]   lut_q [LUT_DEPTH];

  logic              running;
  logic              taken;
  logic              accept;
  logic [PC_W-1:0]   off_ext;
  logic [PC_W-1:0]   target;

  assign running = (state_q == ST_RUN);
  assign taken   = running && bus.branchsig && (bus.cmp != {CMP_W{1'b0}});
  assign accept  = running && !bus.halt && (!inst_valid_q || bus.inst_ready);

  // Relative offsets are signed; the sum wraps modulo 2^PC_W.
  assign off_ext = {{(PC_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
  // The LUT read sees the pre-edge contents, so a same-cycle write to the same index is not forwarded.
  assign target  = bus.branchtype ? (core_q + off_ext) : lut_q[bus.br_index];

  // Next-state: branch beats fetch beats hold; halt/resume arbitration for the FSM.
  always_comb begin
    core_d       = core_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    branch_out_d = taken;
    state_d      = state_q;

    if (taken) begin
      core_d       = target;
      inst_valid_d = 1'b0;
    end else if (accept) begin
      inst_d       = bus.rom_data;
      inst_pc_d    = core_q;
      inst_valid_d = 1'b1;
      core_d       = core_q + {{(PC_W-1){1'b0}}, 1'b1};
    end else if (bus.inst_ready) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN:    if (bus.halt) state_d = ST_HALTED;
      ST_HALTED: if (bus.resume && !bus.halt) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Pipeline registers and halt FSM; synchronous active-low reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      core_q       <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      branch_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_q       <= core_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      branch_out_q <= branch_out_d;
    end
  end

  // Branch-target LUT: writable in any FSM state, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (bus.lut_we) begin
      lut_q[bus.br_index] <= bus.lut_wdata;
    end
  end

  assign bus.rom_addr   = core_q;
  assign bus.core       = core_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.BranchOut  = branch_out_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written corner sequences, then random traffic.
// Every cycle is also compared against a reference model of the fetch rules kept below.
// ROM contents are ROM[a] = a + 0x100 (mod 2^9).
module tb_if_fetch_unit;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rom_data = bus.rom_addr + 9'h100;

  // ---------------- reference model ----------------
  logic [8:0] m_core, m_inst, m_ipc;
  bit         m_v, m_bo, m_h;
  logic [8:0] m_lut [16];

  function automatic logic [8:0] rom(input logic [8:0] a);
    return a + 9'h100;
  endfunction

  task automatic model_step();
    int off;
    int tgt;
    bit run, tk, acc;
    if (reset === 1'b0) begin
      m_core = 9'd0; m_inst = 9'd0; m_ipc = 9'd0;
      m_v = 0; m_bo = 0; m_h = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 9'd0;
      return;
    end
    run = !m_h;
    tk  = run && bus.branchsig && (bus.cmp != 8'd0);
    acc = run && !bus.halt && (!m_v || bus.inst_ready);
    off = int'(bus.br_offset);
    if (off >= 32) off = off - 64;
    if (bus.branchtype) tgt = (int'(m_core) + off + 512) % 512;
    else                tgt = int'(m_lut[bus.br_index]);
    m_bo = tk;
    if (tk) begin
      m_core = tgt[8:0];
      m_v    = 0;
    end else if (acc) begin
      m_inst = rom(m_core);
      m_ipc  = m_core;
      m_v    = 1;
      m_core = m_core + 9'd1;
    end else if (bus.inst_ready) begin
      m_v = 0;
    end
    if (run) m_h = bus.halt;
    else     m_h = !(bus.resume && !bus.halt);
    if (bus.lut_we) m_lut[bus.br_index] = bus.lut_wdata;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("core",       32'(bus.core),       32'(m_core));
    chk("rom_addr",   32'(bus.rom_addr),   32'(m_core));
    chk("inst_valid", 32'(bus.inst_valid), 32'(m_v));
    chk("inst",       32'(bus.inst),       32'(m_inst));
    chk("inst_pc",    32'(bus.inst_pc),    32'(m_ipc));
    chk("halted",     32'(bus.halted),     32'(m_h));
    chk("BranchOut",  32'(bus.BranchOut),  32'(m_bo));
  endtask

  task automatic set_in(input logic h, input logic r, input logic bs, input logic bt,
                        input logic [7:0] cm, input logic [5:0] of, input logic [3:0] ix,
                        input logic we, input logic [8:0] wd, input logic rd);
    bus.halt = h; bus.resume = r; bus.branchsig = bs; bus.branchtype = bt;
    bus.cmp = cm; bus.br_offset = of; bus.br_index = ix;
    bus.lut_we = we; bus.lut_wdata = wd; bus.inst_ready = rd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       halt;
    logic       resume;
    logic       bsig;
    logic       btype;
    logic [7:0] cmp;
    logic [5:0] off;
    logic       rdy;
    logic [8:0] e_core;
    logic       e_v;
    logic [8:0] e_inst;
    logic       e_bo;
    logic       e_h;
  } vec_t;

  vec_t tbl [20];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    set_in(0, 0, 0, 0, 8'd0, 6'd0, 4'd0, 0, 9'd0, 1);

    // reset, sequential fetch, 3-cycle stall, relative branch taken / not taken
    tbl[0]  = '{0, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd0,  0, 9'h000, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd1,  1, 9'h100, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd2,  1, 9'h101, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd3,  1, 9'h102, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd4,  1, 9'h103, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  0, 9'd4,  1, 9'h103, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  0, 9'd4,  1, 9'h103, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  0, 9'd4,  1, 9'h103, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd5,  1, 9'h104, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd6,  1, 9'h105, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd7,  1, 9'h106, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd8,  1, 9'h107, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd9,  1, 9'h108, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd10, 1, 9'h109, 0, 0};
    tbl[14] = '{1, 0, 0, 1, 1, 8'd1, 6'h3C, 1, 9'd6,  0, 9'h109, 1, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd7,  1, 9'h106, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd8,  1, 9'h107, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd9,  1, 9'h108, 0, 0};
    tbl[18] = '{1, 0, 0, 0, 0, 8'd0, 6'd0,  1, 9'd10, 1, 9'h109, 0, 0};
    tbl[19] = '{1, 0, 0, 1, 1, 8'd0, 6'h3C, 1, 9'd11, 1, 9'h10A, 0, 0};

    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst;
      set_in(tbl[i].halt, tbl[i].resume, tbl[i].bsig, tbl[i].btype, tbl[i].cmp,
             tbl[i].off, 4'd0, 0, 9'd0, tbl[i].rdy);
      tick();
      chk($sformatf("vec%0d_core", i),      32'(bus.core),       32'(tbl[i].e_core));
      chk($sformatf("vec%0d_valid", i),     32'(bus.inst_valid), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d_inst", i),      32'(bus.inst),       32'(tbl[i].e_inst));
      chk($sformatf("vec%0d_BranchOut", i), 32'(bus.BranchOut),  32'(tbl[i].e_bo));
      chk($sformatf("vec%0d_halted", i),    32'(bus.halted),     32'(tbl[i].e_h));
    end

    // ---- absolute branch, PC wrap, same-cycle LUT write ----
    set_in(0, 0, 0, 0, 8'd0, 6'd0, 4'd3, 1, 9'h1FF, 1); tick();
    set_in(0, 0, 1, 0, 8'h80, 6'd0, 4'd3, 0, 9'd0, 1);   tick();
    chk("abs_core", 32'(bus.core), 32'h1FF);
    chk("abs_pulse", 32'(bus.BranchOut), 32'd1);
    set_in(0, 0, 0, 0, 8'd0, 6'd0, 4'd0, 0, 9'd0, 1);    tick();
    chk("wrap_core", 32'(bus.core), 32'h000);
    chk("wrap_inst_pc", 32'(bus.inst_pc), 32'h1FF);
    chk("wrap_pulse_clear", 32'(bus.BranchOut), 32'd0);
    set_in(0, 0, 1, 0, 8'd1, 6'd0, 4'd3, 1, 9'h050, 1);  tick();
    chk("lut_same_cycle_old", 32'(bus.core), 32'h1FF);
    set_in(0, 0, 1, 0, 8'd1, 6'd0, 4'd3, 0, 9'd0, 1);    tick();
    chk("lut_new_value", 32'(bus.core), 32'h050);

    // ---- halt / resume at core = 20 ----
    set_in(0, 0, 0, 0, 8'd0, 6'd0, 4'd5, 1, 9'd20, 1);   tick();
    set_in(0, 0, 1, 0, 8'd1, 6'd0, 4'd5, 0, 9'd0, 1);    tick();
    chk("goto20", 32'(bus.core), 32'd20);
    set_in(1, 0, 0, 0, 8'd0, 6'd0, 4'd0, 0, 9'd0, 1);    tick();
    chk("halt_enter", 32'(bus.halted), 32'd1);
    chk("halt_core_hold", 32'(bus.core), 32'd20);
    set_in(0, 0, 1, 1, 8'd1, 6'd5, 4'd0, 0, 9'd0, 1);    tick();
    chk("halt_branch_ignored", 32'(bus.core), 32'd20);
    chk("halt_no_pulse", 32'(bus.BranchOut), 32'd0);
    set_in(1, 1, 0, 0, 8'd0, 6'd0, 4'd0, 0, 9'd0, 1);    tick();
    chk("halt_and_resume", 32'(bus.halted), 32'd1);
    set_in(0, 1, 0, 0, 8'd0, 6'd0, 4'd0, 0, 9'd0, 1);    tick();
    chk("resume_run", 32'(bus.halted), 32'd0);
    chk("resume_core", 32'(bus.core), 32'd20);
    set_in(0, 0, 0, 0, 8'd0, 6'd0, 4'd0, 0, 9'd0, 1);    tick();
    chk("resume_fetch_core", 32'(bus.core), 32'd21);
    chk("resume_fetch_inst", 32'(bus.inst), 32'h114);
    chk("resume_fetch_pc", 32'(bus.inst_pc), 32'd20);

    // ---- reset while halted with a pending instruction ----
    set_in(1, 0, 0, 0, 8'd0, 6'd0, 4'd0, 0, 9'd0, 0);    tick();
    chk("halt_pending_valid", 32'(bus.inst_valid), 32'd1);
    chk("halt_pending_halted", 32'(bus.halted), 32'd1);
    reset = 1'b0;                                         tick();
    reset = 1'b1;
    chk("rst_core", 32'(bus.core), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    set_in(0, 0, 0, 0, 8'd0, 6'd0, 4'd0, 0, 9'd0, 1);    tick();
    chk("rst_fetch", 32'(bus.core), 32'd1);
    set_in(0, 0, 1, 0, 8'd1, 6'd0, 4'd3, 0, 9'd0, 1);    tick();
    chk("rst_lut_cleared", 32'(bus.core), 32'd0);

    // ---- random traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 63) != 0);
      bus.halt       = ($urandom_range(0, 15) == 0);
      bus.resume     = ($urandom_range(0, 3) == 0);
      bus.branchsig  = ($urandom_range(0, 7) == 0);
      bus.branchtype = 1'($urandom_range(0, 1));
      bus.cmp        = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      bus.br_offset  = 6'($urandom);
      bus.br_index   = 4'($urandom);
      bus.lut_we     = ($urandom_range(0, 7) == 0);
      bus.lut_wdata  = 9'($urandom);
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised instruction-fetch stage: owns the PC, drives the combinational InstROM address, and registers the fetched instruction toward decode with a valid/ready handshake.
- Generalises the existing IF block with parametrised widths, relative and LUT-absolute branch modes, a programmable branch-target LUT, decode back-pressure, and a halt/resume state machine.

Parameters:
- PC_W, 9, PC and ROM address width.
- INST_W, 9, instruction width.
- CMP_W, 8, width of the compare-result input.
- OFF_W, 6, signed relative-branch offset width.
- LUT_DEPTH, 16, number of absolute branch-target entries (power of 2); IDX_W = log2(LUT_DEPTH).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- halt  in  1  request to stop fetching.
- resume  in  1  request to leave HALTED.
- branchsig  in  1  branch instruction in execute.
- branchtype  in  1  1 = relative (PC + offset), 0 = absolute (lut[br_index]).
- cmp  in  CMP_W  compare result; branch taken only if cmp != 0.
- br_offset  in  OFF_W  signed relative offset.
- br_index  in  IDX_W  LUT index for absolute branches and for LUT writes.
- lut_we  in  1  write enable for lut[br_index].
- lut_wdata  in  PC_W  LUT write data.
- rom_addr  out  PC_W  equals core (combinational).
- rom_data  in  INST_W  combinational ROM read data.
- core  out  PC_W  current PC.
- inst  out  INST_W  registered instruction.
- inst_pc  out  PC_W  PC of inst.
- inst_valid  out  1  inst holds a valid instruction.
- inst_ready  in  1  decode accepts inst this cycle.
- halted  out  1  state == HALTED.
- BranchOut  out  1  one-cycle pulse when a branch is taken.

Behaviour:
- Reset (reset == 0 at a clock edge): core = RESET_PC; inst = 0; inst_pc = 0; inst_valid = 0; BranchOut = 0; state = RUN; all LUT entries = 0. Reset overrides every other input, including mid-stall and mid-halt.
- States: RUN, HALTED. halted = (state == HALTED).
- taken = (state == RUN) && branchsig && (cmp != 0).
- accept = (state == RUN) && !halt && (!inst_valid || inst_ready).
- Priority in RUN, per cycle:
  1. taken: core <= target; inst_valid <= 0 (wrong-path flush, even if decode is stalled); BranchOut <= 1.
  2. else accept: inst <= rom_data; inst_pc <= core; inst_valid <= 1; core <= core + 1.
  3. else: core holds; inst/inst_valid hold, except inst_valid <= 0 when inst_ready && inst_valid.
- BranchOut = 0 on any cycle not following a taken branch.
- Target arithmetic, modulo 2^PC_W:
  - relative: core + sign_extend(br_offset).
  - absolute: lut[br_index].
  - core + 1 wraps from 2^PC_W-1 to 0.
- Fetch latency: instruction at address A appears on inst one cycle after core == A is accepted. Sustained rate is 1 instruction/cycle while inst_ready = 1.
- Halt:
  - RUN with halt = 1 -> HALTED next cycle; no fetch that cycle, core holds.
  - halt and taken in the same cycle: the branch applies, then HALTED.
  - In HALTED: no fetch, core holds, branchsig ignored. A pending inst_valid is still consumed by inst_ready.
  - HALTED with resume = 1 and halt = 0 -> RUN; fetching restarts next cycle from the held core.
  - halt and resume both 1 -> remain HALTED.
- LUT:
  - lut_we writes lut[br_index] at the clock edge, in any state.
  - An absolute branch in the same cycle as a write to the same index uses the old entry.
- No combinational path from inst_ready to inst_valid.

Test Plan:
- Sequential fetch: reset low 1 cycle, ROM[i] = i+0x100, inst_ready = 1 -> core 0,1,2,...; inst = 0x100 at cycle 2, inst_pc = 0; inst_valid continuously 1.
- Stall: drop inst_ready for 3 cycles while inst = 0x103 -> inst, inst_pc and core frozen. Release -> 0x104 next cycle, no skip or duplicate.
- Relative branch: at core = 10, branchsig = 1, branchtype = 1, cmp = 0x01, br_offset = -4 -> core = 6, BranchOut 1 for exactly one cycle, inst_valid 0 for one cycle. Same stimulus with cmp = 0 -> core = 11, no pulse.
- Absolute branch and wrap: write lut[3] = 0x1FF, then branch with branchtype = 0, br_index = 3 -> core = 0x1FF, then 0x000. Same-cycle write of 0x050 to index 3 plus branch -> old value used.
- Halt/resume: halt at core = 20 -> halted = 1 next cycle, core stays 20, branches ignored. halt and resume together -> still halted. resume alone -> fetch of 20 resumes.
- Reset mid-operation: reset low while HALTED with inst_valid = 1 -> core = RESET_PC, inst_valid = 0, halted = 0, LUT cleared.
